// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Single-issue ALU execute stage. Most operations complete at the edge that
//   accepts them. MUL is an unsigned 32x32->64 shift-add multiply that runs
//   for 32 cycles and writes the product into hi/lo when it finishes.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          execute alu_control_in on a/b (ignored while busy)
//   alu_control_in 000 ADD, 001 SUB, 010 AND, 011 MUL, 100 SLT, 101 OR,
//                  110 XOR, 111 MFLO
//   a, b           operands, sampled only at the accepting edge
//   result, zero   registered result and its zero flag
//   result_valid   one-cycle pulse marking a new result/zero
//   busy           multiply in progress
//   hi, lo         product registers
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | ready; a start is accepted on any edge
// ST_MUL   | one shift-add step per cycle, 32 steps, start ignored

module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  alu_control_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero,
    output logic        result_valid,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MFLO = 3'b111;

    logic [0:0]  state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [63:0] acc;
    logic [5:0]  cnt;

    logic [31:0] alu_out;
    logic [63:0] addend;
    logic [63:0] acc_next;
    logic        accept;

    assign busy   = (state == ST_MUL);
    assign accept = start && (state == ST_IDLE);

    always_comb begin
        alu_out = 32'd0;
        case (alu_control_in)
            OP_ADD:  alu_out = a + b;
            OP_SUB:  alu_out = a - b;
            OP_AND:  alu_out = a & b;
            OP_SLT:  alu_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_OR:   alu_out = a | b;
            OP_XOR:  alu_out = a ^ b;
            OP_MFLO: alu_out = lo;
            default: alu_out = 32'd0;
        endcase
    end

    // Step i adds multiplicand<<i when multiplier bit i is set.
    always_comb begin
        addend = 64'd0;
        if (mplier[cnt[4:0]]) begin
            addend = {32'd0, mcand} << cnt[4:0];
        end
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mcand        <= 32'd0;
            mplier       <= 32'd0;
            acc          <= 64'd0;
            cnt          <= 6'd0;
            result       <= 32'd0;
            zero         <= 1'b1;
            result_valid <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (alu_control_in == OP_MUL) begin
                            state  <= ST_MUL;
                            mcand  <= a;
                            mplier <= b;
                            acc    <= 64'd0;
                            cnt    <= 6'd0;
                        end else begin
                            result       <= alu_out;
                            zero         <= (alu_out == 32'd0);
                            result_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state        <= ST_IDLE;
                        hi           <= acc_next[63:32];
                        lo           <= acc_next[31:0];
                        result       <= acc_next[31:0];
                        zero         <= (acc_next[31:0] == 32'd0);
                        result_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  alu_control_in;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        result_valid;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    alu_exec_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .alu_control_in (alu_control_in),
        .a              (a),
        .b              (b),
        .result         (result),
        .zero           (zero),
        .result_valid   (result_valid),
        .busy           (busy),
        .hi             (hi),
        .lo             (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one start for one edge; outputs are then sampled 1 ns after it.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        alu_control_in = op;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_result got=%h exp=%h", result, 32'd0); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", zero); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", result_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL rst_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL rst_lo got=%h exp=0", lo); end
    endtask

    task automatic test_add_wrap;
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
        total++; if (result !== 32'h0) begin bad++; $display("FAIL add_wrap got=%h exp=0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL add_zero got=%b exp=1", zero); end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", result_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy got=%b exp=0", busy); end
        a = 32'h1234_5678;
        @(posedge clk); #1;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL add_pulse_end got=%b exp=0", result_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL add_hold got=%h exp=0", result); end
    endtask

    task automatic test_slt_sub;
        issue(3'b100, 32'hFFFF_FFFE, 32'h0000_0003);
        total++; if (result !== 32'd1) begin bad++; $display("FAIL slt_neg got=%h exp=1", result); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL slt_zero got=%b exp=0", zero); end
        issue(3'b100, 32'h0000_0003, 32'hFFFF_FFFE);
        total++; if (result !== 32'd0) begin bad++; $display("FAIL slt_pos got=%h exp=0", result); end
        issue(3'b001, 32'd5, 32'd5);
        total++; if (result !== 32'd0) begin bad++; $display("FAIL sub_eq got=%h exp=0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL sub_zero got=%b exp=1", zero); end
        issue(3'b001, 32'd3, 32'd5);
        total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_wrap got=%h exp=fffffffe", result); end
    endtask

    task automatic test_mul;
        int n;
        issue(3'b011, 32'hFFFF_FFFF, 32'h0000_0002);
        // Operand changes while busy must not disturb the product.
        a = 32'h0; b = 32'h0; alu_control_in = 3'b000;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL mul_early_valid cyc=%0d got=%b exp=0", n, result_valid); end
            n++;
            @(posedge clk); #1;
        end
        total++; if (n !== 32) begin bad++; $display("FAIL mul_busy_len got=%0d exp=32", n); end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL mul_valid got=%b exp=1", result_valid); end
        total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL mul_hi got=%h exp=00000001", hi); end
        total++; if (lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_lo got=%h exp=fffffffe", lo); end
        total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_result got=%h exp=fffffffe", result); end
        // MFLO in the completion cycle must be accepted and see the new lo.
        issue(3'b111, 32'h0, 32'h0);
        total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mflo got=%h exp=fffffffe", result); end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL mflo_valid got=%b exp=1", result_valid); end
    endtask

    task automatic test_start_during_mul;
        int n;
        issue(3'b011, 32'h1234_5678, 32'h0000_0100);
        alu_control_in = 3'b110; a = 32'hAAAA_AAAA; b = 32'h5555_5555; start = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL xor_during_mul_valid cyc=%0d got=%b exp=0", n, result_valid); end
            total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL xor_during_mul_result cyc=%0d got=%h exp=fffffffe", n, result); end
            n++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++; if (n !== 32) begin bad++; $display("FAIL mul2_busy_len got=%0d exp=32", n); end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL mul2_valid got=%b exp=1", result_valid); end
        total++; if (hi !== 32'h0000_0012) begin bad++; $display("FAIL mul2_hi got=%h exp=00000012", hi); end
        total++; if (lo !== 32'h3456_7800) begin bad++; $display("FAIL mul2_lo got=%h exp=34567800", lo); end
        total++; if (result !== 32'h3456_7800) begin bad++; $display("FAIL mul2_result got=%h exp=34567800", result); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops [4];
        logic [31:0] exp [4];
        ops[0] = 3'b010; exp[0] = 32'h00F0_00F0;
        ops[1] = 3'b101; exp[1] = 32'hFFF0_FFF0;
        ops[2] = 3'b110; exp[2] = 32'hFF00_FF00;
        ops[3] = 3'b000; exp[3] = 32'h00E1_00E0;
        a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_control_in = ops[i];
            @(posedge clk); #1;
            total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid idx=%0d got=%b exp=1", i, result_valid); end
            total++; if (result !== exp[i]) begin bad++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, result, exp[i]); end
        end
        start = 1'b0;
        @(posedge clk); #1;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", result_valid); end
        total++; if (hi !== 32'h0000_0012) begin bad++; $display("FAIL b2b_hi_kept got=%h exp=00000012", hi); end
        total++; if (lo !== 32'h3456_7800) begin bad++; $display("FAIL b2b_lo_kept got=%h exp=34567800", lo); end
    endtask

    task automatic test_reset_mid_mul;
        int n;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", result_valid); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL midrst_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL midrst_lo got=%h exp=0", lo); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL midrst_result got=%h exp=0", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL midrst_zero got=%b exp=1", zero); end
        @(posedge clk); #1;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid_hold got=%b exp=0", result_valid); end
        rst_n = 1'b1;
        issue(3'b011, 32'd3, 32'd7);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL postrst_busy got=%b exp=1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        total++; if (n !== 32) begin bad++; $display("FAIL mul3_busy_len got=%0d exp=32", n); end
        total++; if (lo !== 32'd21) begin bad++; $display("FAIL mul3_lo got=%h exp=00000015", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL mul3_hi got=%h exp=0", hi); end
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL mul3_valid got=%b exp=1", result_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        alu_control_in = 3'b000;
        a = 32'h0;
        b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_add_wrap();
        test_slt_sub();
        test_mul();
        test_start_during_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have port start  input  1  request to execute alu_control_in on a/b this cycle.
REQ-003 The block SHALL have port alu_control_in  input  3  operation code from the ALU control decoder.
REQ-004 The block SHALL have ports a  input  32  operand A (rs) and b  input  32  operand B (rt/immediate).
REQ-005 The block SHALL have port result  output  32  registered operation result.
REQ-006 The block SHALL have port zero  output  1  registered flag, 1 iff result == 0.
REQ-007 The block SHALL have port result_valid  output  1  one-cycle pulse marking a new result/zero.
REQ-008 The block SHALL have port busy  output  1  multiply in progress; start ignored while high.
REQ-009 The block SHALL have ports hi  output  32  and lo  output  32  product registers.

Function
REQ-010 Op codes SHALL be: 000 ADD, 001 SUB (a-b), 010 AND, 011 MUL (unsigned 32x32->64, iterative), 100 SLT (signed, result 1/0), 101 OR, 110 XOR, 111 MFLO (result = lo).
REQ-011 ADD/SUB SHALL wrap modulo 2^32; no overflow detection or trap.
REQ-012 A start is accepted on a rising edge where start=1 and state=IDLE; start while busy=1 SHALL be ignored with no side effects.
REQ-013 Non-MUL ops SHALL register result and zero at the accepting edge; result_valid=1 for exactly the following cycle; busy stays 0.
REQ-014 Back-to-back non-MUL starts SHALL be accepted every cycle, one result_valid pulse per start.
REQ-015 FSM states SHALL be IDLE and MUL; IDLE->MUL on accepted op 011; MUL->IDLE after the 32nd iteration; no other transitions except reset.
REQ-016 On MUL accept the block SHALL latch a and b, clear a 64-bit accumulator, load a 6-bit counter with 0, and assert busy from the next cycle.
REQ-017 Each cycle in MUL SHALL perform one shift-add step (add multiplicand<<i to accumulator if multiplier bit i set), counter increments by 1.
REQ-018 busy SHALL be high for exactly 32 cycles; on the edge completing iteration 31 the block SHALL write hi=product[63:32], lo=product[31:0], result=product[31:0], zero accordingly, return to IDLE.
REQ-019 result_valid SHALL pulse in the first cycle busy is low after a MUL; a start in that same cycle SHALL be accepted.
REQ-020 hi/lo SHALL change only on MUL completion or reset; MFLO issued immediately after MUL completion SHALL return the new lo.
REQ-021 result and zero SHALL hold their last values when result_valid=0.
REQ-022 alu_control_in, a and b SHALL be sampled only at the accepting edge; changes during MUL SHALL not affect the product.

Reset
REQ-023 While rst_n=0 (asynchronously) the block SHALL force state=IDLE, result=0, zero=1, result_valid=0, busy=0, hi=0, lo=0, counter=0, accumulator=0.
REQ-024 Reset asserted mid-MUL SHALL abort the operation with no result_valid pulse and hi/lo=0.
REQ-025 After rst_n deasserts, a start on the first rising edge SHALL be accepted normally.

Verification
REQ-026 ADD a=0xFFFFFFFF b=0x00000001 -> next cycle result=0x00000000, zero=1, result_valid=1 for one cycle.
REQ-027 SLT a=0xFFFFFFFE(-2) b=0x00000003 -> result=1; SUB a=5 b=5 -> result=0, zero=1.
REQ-028 MUL a=0xFFFFFFFF b=0x00000002 -> busy high 32 cycles, then hi=0x00000001, lo=0xFFFFFFFE, result=0xFFFFFFFE, result_valid pulse; then MFLO -> result=0xFFFFFFFE.
REQ-029 Start XOR pulsed every cycle during a MUL -> no result_valid, result unchanged until MUL completes; product correct.
REQ-030 rst_n low at MUL iteration 10 -> all outputs at reset values, no result_valid; subsequent MUL 3x7 -> lo=21, hi=0.
REQ-031 Four back-to-back non-MUL starts (AND, OR, XOR, ADD) -> four consecutive result_valid cycles with correct values.
